cdb_arbiter: RTL

//   Shares the single common data bus (CDB) among the completing functional units (ALU, LSB, Branch, ...).

---
 rtl/cdb_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cdb_if.sv
// Common data bus bundle: per-unit result offers into the arbiter and the
// single registered broadcast leaving it.
interface cdb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TW   = 4
);
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*TW-1:0] req_tag;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               cdb_valid;
  logic [TW-1:0]      cdb_tag;
  logic [DW-1:0]      cdb_data;
  logic [SRCW-1:0]    cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one small FIFO per functional unit, round-robin selection of a
// non-empty head, one registered {tag,data} broadcast per cycle.
module cdb_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  cdb_if.slave bus
);
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int EW   = TW + DW;

  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    ready;
  logic [NREQ-1:0]    push;
  logic [NREQ-1:0]    pop;
  logic [NREQ*EW-1:0] heads;
  logic [SRCW-1:0]    rr_ptr;
  logic [SRCW-1:0]    win_idx;
  logic               win_found;
  logic [EW-1:0]      win_entry;
  logic               advance;

  function automatic logic [SRCW-1:0] wrap_idx(input logic [SRCW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return SRCW'(s);
  endfunction

  assign advance       = rdy & ~clear;
  assign bus.req_ready = ready;

  // Scan offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign win_entry = heads[win_idx*EW +: EW];

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign eligible[g]       = (count != '0);
    assign ready[g]          = (count != CW'(DEPTH));
    assign push[g]           = advance & bus.req_valid[g] & ready[g];
    assign pop[g]            = advance & win_found & (win_idx == SRCW'(g));
    assign heads[g*EW +: EW] = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (rdy) begin
        if (clear) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push[g]) wr_ptr <= wr_ptr + PW'(1);
          if (pop[g])  rd_ptr <= rd_ptr + PW'(1);
          case ({push[g], pop[g]})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= {bus.req_tag[g*TW +: TW], bus.req_data[g*DW +: DW]};
    end
  end

  // Broadcast stage: registered CDB outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
    end else if (rdy) begin
      if (clear) begin
        rr_ptr        <= '0;
        bus.cdb_valid <= 1'b0;
        bus.cdb_tag   <= '0;
        bus.cdb_data  <= '0;
      end else if (win_found) begin
        rr_ptr        <= wrap_idx(win_idx, 1);
        bus.cdb_valid <= 1'b1;
        bus.cdb_tag   <= win_entry[EW-1 -: TW];
        bus.cdb_data  <= win_entry[DW-1:0];
        bus.cdb_src   <= win_idx;
      end else begin
        bus.cdb_valid <= 1'b0;
        bus.cdb_tag   <= '0;
        bus.cdb_data  <= '0;
      end
    end
  end
endmodule
